dma_reg_sequencer: RTL and testbench

AXI4-Lite master that sits between `dma_controller` and the AXI DMA's register slave. It accepts one register-programming request, framed by an init pulse with address, data, mode and transaction count. It then performs the required sequence of AXI-Lite register writes, optionally polls for completion, and returns a one-cycle `O_AXI_TXN_DONE` pulse.

---
 rtl/dma_reg_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_dma_reg_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reg_sequencer.sv
// AXI4-Lite master that programs AXI DMA registers for one request, then pulses done.
// Optional SR completion polling and clearing: define DMA_REG_SEQ_POLL_EN.
module dma_reg_sequencer #(
  parameter logic [31:0] C_DMA_BASE_ADDR = 32'h4040_0000,
  parameter int unsigned C_POLL_LIMIT    = 1024
) (
  input  logic        I_ACLK,
  input  logic        I_ARESET,
  input  logic        I_INIT_AXI_TXN,
  input  logic [31:0] I_REG_ADDRESS,
  input  logic [31:0] I_REG_DATA,
  input  logic [1:0]  I_TRANSFER_MODE,
  input  logic [31:0] I_NO_OF_TRANSACTION,
  output logic        O_AXI_TXN_DONE,
  output logic        O_ERROR,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_WR_ADDR_DATA = 4'd1;
  localparam logic [3:0] ST_WR_RESP      = 4'd2;
  localparam logic [3:0] ST_NEXT         = 4'd3;
  localparam logic [3:0] ST_DONE         = 4'd4;
`ifdef DMA_REG_SEQ_POLL_EN
  localparam logic [3:0] ST_POLL_AR      = 4'd5;
  localparam logic [3:0] ST_POLL_R       = 4'd6;
  localparam logic [3:0] ST_CLR_WR       = 4'd7;
  localparam logic [3:0] ST_CLR_RESP     = 4'd8;
`endif

  logic [3:0]  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] data_q, data_d, n_q, n_d, k_q, k_d, da_q, da_d;
  logic        s_q, s_d, err_q, err_d, done_q, done_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic        aw_ok_c, w_ok_c, last_c;

  // Register offset/value of write step s: step 0 programs control or address, step 1 length.
  function automatic logic [63:0] wr_target(input logic [1:0] mode, input logic step,
                                            input logic [31:0] da, input logic [31:0] len);
    logic [31:0] off;
    logic [31:0] val;
    off = 32'h0;
    val = len;
    case (mode)
      2'd0:    off = step ? 32'h30 : 32'h00;
      2'd1:    begin off = step ? 32'h28 : 32'h18; val = step ? len : da; end
      default: begin off = step ? 32'h58 : 32'h48; val = step ? len : da; end
    endcase
    return {C_DMA_BASE_ADDR + off, val};
  endfunction

  assign aw_ok_c = ~awvalid_q | M_AXI_AWREADY;
  assign w_ok_c  = ~wvalid_q | M_AXI_WREADY;
  assign last_c  = s_q & ((k_q + 32'd1) == n_q);

`ifdef DMA_REG_SEQ_POLL_EN
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0] araddr_q, araddr_d, poll_cnt_q, poll_cnt_d;
  logic        unused_rd;
  assign unused_rd     = ^{M_AXI_RDATA[31:13], M_AXI_RDATA[11:7], M_AXI_RDATA[3:0]};
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
`else
  logic unused_rd;
  assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, 32'(C_POLL_LIMIT)};
  assign M_AXI_ARADDR  = 32'h0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    data_d    = data_q;
    n_d       = n_q;
    k_d       = k_q;
    da_d      = da_q;
    s_d       = s_q;
    err_d     = err_q;
    done_d    = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bready_d  = bready_q;
`ifdef DMA_REG_SEQ_POLL_EN
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
    poll_cnt_d = poll_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (I_INIT_AXI_TXN) begin
          mode_d = I_TRANSFER_MODE;
          data_d = I_REG_DATA;
          da_d   = I_REG_ADDRESS;
          n_d    = (I_TRANSFER_MODE == 2'd2 && I_NO_OF_TRANSACTION != 32'd0) ?
                   I_NO_OF_TRANSACTION : 32'd1;
          k_d    = 32'd0;
          s_d    = 1'b0;
          err_d  = 1'b0;
          if (I_TRANSFER_MODE == 2'd3) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            {awaddr_d, wdata_d} = wr_target(I_TRANSFER_MODE, 1'b0, I_REG_ADDRESS, I_REG_DATA);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR_DATA;
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (aw_ok_c && w_ok_c) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
`ifdef DMA_REG_SEQ_POLL_EN
          else if (s_q && mode_q != 2'd0) begin
            arvalid_d  = 1'b1;
            araddr_d   = C_DMA_BASE_ADDR + ((mode_q == 2'd1) ? 32'h04 : 32'h34);
            poll_cnt_d = 32'd0;
            state_d    = ST_POLL_AR;
          end
`endif
          else if (last_c) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        // Address for iteration k+1 accumulates one length past the previous one.
        if (s_q) begin
          s_d  = 1'b0;
          k_d  = k_q + 32'd1;
          da_d = da_q + data_q;
          {awaddr_d, wdata_d} = wr_target(mode_q, 1'b0, da_q + data_q, data_q);
        end else begin
          s_d = 1'b1;
          {awaddr_d, wdata_d} = wr_target(mode_q, 1'b1, da_q, data_q);
        end
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = ST_WR_ADDR_DATA;
      end
`ifdef DMA_REG_SEQ_POLL_EN
      ST_POLL_AR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_POLL_R;
        end
      end
      ST_POLL_R: begin
        if (M_AXI_RVALID) begin
          rready_d   = 1'b0;
          poll_cnt_d = poll_cnt_q + 32'd1;
          if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA[6:4] != 3'd0) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (M_AXI_RDATA[12]) begin
            awaddr_d  = araddr_q;
            wdata_d   = 32'h0000_1000;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_CLR_WR;
          end else if ((poll_cnt_q + 32'd1) >= 32'(C_POLL_LIMIT)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_POLL_AR;
          end
        end
      end
      ST_CLR_WR: begin
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (aw_ok_c && w_ok_c) begin
          bready_d = 1'b1;
          state_d  = ST_CLR_RESP;
        end
      end
      ST_CLR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (last_c) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_ACLK or posedge I_ARESET) begin
    if (I_ARESET) begin
      state_q   <= ST_IDLE;
      mode_q    <= 2'd0;
      data_q    <= 32'd0;
      n_q       <= 32'd1;
      k_q       <= 32'd0;
      da_q      <= 32'd0;
      s_q       <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= 32'd0;
      wdata_q   <= 32'd0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      n_q       <= n_d;
      k_q       <= k_d;
      da_q      <= da_d;
      s_q       <= s_d;
      err_q     <= err_d;
      done_q    <= done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      bready_q  <= bready_d;
    end
  end

`ifdef DMA_REG_SEQ_POLL_EN
  always_ff @(posedge I_ACLK or posedge I_ARESET) begin
    if (I_ARESET) begin
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= 32'd0;
      poll_cnt_q <= 32'd0;
    end else begin
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end
`endif

  assign O_AXI_TXN_DONE = done_q;
  assign O_ERROR        = err_q;
  assign M_AXI_AWADDR   = awaddr_q;
  assign M_AXI_AWVALID  = awvalid_q;
  assign M_AXI_WDATA    = wdata_q;
  assign M_AXI_WSTRB    = 4'hF;
  assign M_AXI_WVALID   = wvalid_q;
  assign M_AXI_BREADY   = bready_q;

endmodule

// File: tb/tb_dma_reg_sequencer.sv
// Directed bench for dma_reg_sequencer: AXI-Lite slave model plus a write scoreboard.
module tb_dma_reg_sequencer;

  logic        clk = 1'b0;
  logic        I_ARESET, I_INIT_AXI_TXN;
  logic [31:0] I_REG_ADDRESS, I_REG_DATA, I_NO_OF_TRANSACTION;
  logic [1:0]  I_TRANSFER_MODE;
  logic        O_AXI_TXN_DONE, O_ERROR;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 clk = ~clk;

  dma_reg_sequencer dut (
    .I_ACLK(clk), .I_ARESET(I_ARESET), .I_INIT_AXI_TXN(I_INIT_AXI_TXN),
    .I_REG_ADDRESS(I_REG_ADDRESS), .I_REG_DATA(I_REG_DATA),
    .I_TRANSFER_MODE(I_TRANSFER_MODE), .I_NO_OF_TRANSACTION(I_NO_OF_TRANSACTION),
    .O_AXI_TXN_DONE(O_AXI_TXN_DONE), .O_ERROR(O_ERROR),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Slave configuration, written by the stimulus only.
  int          aw_delay = 0;
  int          err_at = -1;
  int          sr_base = 0;
  int          sr_len = 0;
  logic [31:0] sr_arr [8];

  // Slave/monitor state, written by the monitor only.
  int          cyc = 0, wr_n = 0, aw_n = 0, rd_n = 0, done_n = 0;
  int          done_cyc = 0, last_b_cyc = 0, aw_cnt = 0, wdrop_n = 0, unstable_n = 0;
  logic        have_aw = 1'b0, have_w = 1'b0, ar_pend = 1'b0, aw_wait_prev = 1'b0;
  logic [31:0] aw_hold = '0, w_hold = '0, aw_prev = '0, last_ar = '0;
  logic [31:0] cap_addr [64];
  logic [31:0] cap_data [64];

  initial begin
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
  end

  // Slave model: decisions at negedge take effect on the following posedge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (O_AXI_TXN_DONE) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (I_ARESET) begin
      have_aw <= 1'b0; have_w <= 1'b0; ar_pend <= 1'b0; aw_cnt <= 0; aw_wait_prev <= 1'b0;
      M_AXI_AWREADY <= 1'b0; M_AXI_WREADY <= 1'b0; M_AXI_BVALID <= 1'b0;
      M_AXI_ARREADY <= 1'b0; M_AXI_RVALID <= 1'b0;
    end else begin
      if (have_aw && have_w && M_AXI_BREADY) begin
        M_AXI_BVALID <= 1'b1;
        M_AXI_BRESP  <= (wr_n == err_at) ? 2'b10 : 2'b00;
        cap_addr[wr_n % 64] <= aw_hold;
        cap_data[wr_n % 64] <= w_hold;
        wr_n       <= wr_n + 1;
        last_b_cyc <= cyc;
        have_aw    <= 1'b0;
        have_w     <= 1'b0;
      end else begin
        M_AXI_BVALID <= 1'b0;
        M_AXI_BRESP  <= 2'b00;
      end
      if (M_AXI_AWVALID) begin
        if (aw_cnt >= aw_delay) begin
          M_AXI_AWREADY <= 1'b1; aw_hold <= M_AXI_AWADDR; have_aw <= 1'b1;
          aw_n <= aw_n + 1; aw_cnt <= 0;
        end else begin
          M_AXI_AWREADY <= 1'b0; aw_cnt <= aw_cnt + 1;
        end
      end else begin
        M_AXI_AWREADY <= 1'b0; aw_cnt <= 0;
      end
      if (M_AXI_WVALID) begin
        M_AXI_WREADY <= 1'b1; w_hold <= M_AXI_WDATA; have_w <= 1'b1;
      end else begin
        M_AXI_WREADY <= 1'b0;
      end
      if (M_AXI_AWVALID && !M_AXI_WVALID) wdrop_n <= wdrop_n + 1;
      if (aw_wait_prev && M_AXI_AWVALID && M_AXI_AWADDR != aw_prev) unstable_n <= unstable_n + 1;
      aw_wait_prev <= M_AXI_AWVALID && (aw_cnt < aw_delay);
      aw_prev      <= M_AXI_AWADDR;
      if (M_AXI_ARVALID) begin
        M_AXI_ARREADY <= 1'b1; ar_pend <= 1'b1; last_ar <= M_AXI_ARADDR;
      end else begin
        M_AXI_ARREADY <= 1'b0;
      end
      if (ar_pend && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= (rd_n - sr_base < sr_len) ? sr_arr[3'(rd_n - sr_base)] : 32'h0000_1000;
        rd_n    <= rd_n + 1;
        ar_pend <= 1'b0;
      end else begin
        M_AXI_RVALID <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Issue one request and wait (bounded) for its done pulse plus settling time.
  task automatic run(input string tag, input logic [1:0] m, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] n);
    int d0;
    d0 = done_n;
    @(negedge clk);
    I_TRANSFER_MODE = m; I_REG_ADDRESS = a; I_REG_DATA = d; I_NO_OF_TRANSACTION = n;
    I_INIT_AXI_TXN = 1'b1;
    @(negedge clk);
    I_INIT_AXI_TXN = 1'b0;
    for (int i = 0; i < 3000 && done_n == d0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_n), 32'(d0 + 1));
  endtask

  int rd_ptr = 0;
  task automatic check_writes(input string tag);
    wr_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_awaddr"}, cap_addr[rd_ptr % 64], e.a);
      chk({tag, "_wdata"}, cap_data[rd_ptr % 64], e.d);
      rd_ptr++;
    end
    chk({tag, "_write_count"}, 32'(wr_n), 32'(rd_ptr));
  endtask

  initial begin
    int aw0;
    int wd0;
    I_ARESET = 1'b1; I_INIT_AXI_TXN = 1'b0; I_REG_ADDRESS = '0; I_REG_DATA = '0;
    I_TRANSFER_MODE = '0; I_NO_OF_TRANSACTION = '0;
    for (int i = 0; i < 8; i++) sr_arr[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);
    chk("rst_wvalid", {31'd0, M_AXI_WVALID}, 32'd0);
    chk("rst_bready", {31'd0, M_AXI_BREADY}, 32'd0);
    chk("rst_arvalid_rready", {30'd0, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    chk("rst_awaddr", M_AXI_AWADDR, 32'd0);
    chk("rst_wdata", M_AXI_WDATA, 32'd0);
    chk("rst_araddr", M_AXI_ARADDR, 32'd0);
    chk("rst_done_err", {30'd0, O_AXI_TXN_DONE, O_ERROR}, 32'd0);
    I_ARESET = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 1, all slaves ready immediately.
    push(32'h4040_0018, 32'h1000_0000);
    push(32'h4040_0028, 32'd64);
`ifdef DMA_REG_SEQ_POLL_EN
    push(32'h4040_0004, 32'h0000_1000);
`endif
    run("mode1", 2'd1, 32'h1000_0000, 32'd64, 32'd0);
    check_writes("mode1");
    chk("mode1_error", {31'd0, O_ERROR}, 32'd0);
    chk("mode1_wstrb", {28'd0, M_AXI_WSTRB}, 32'hF);

    // Mode 2, three iterations with incrementing buffer address.
    for (int k = 0; k < 3; k++) begin
      push(32'h4040_0048, 32'h2000_0000 + 32'(k) * 32'd16);
      push(32'h4040_0058, 32'd16);
`ifdef DMA_REG_SEQ_POLL_EN
      push(32'h4040_0034, 32'h0000_1000);
`endif
    end
    run("mode2", 2'd2, 32'h2000_0000, 32'd16, 32'd3);
    check_writes("mode2");
    chk("mode2_done_latency", 32'(done_cyc), 32'(last_b_cyc + 1));
    chk("mode2_error", {31'd0, O_ERROR}, 32'd0);

    // Mode 0 with AWREADY held off: W accepted first, AW address must stay put.
    aw_delay = 4;
    wd0 = wdrop_n;
    push(32'h4040_0000, 32'd1);
    push(32'h4040_0030, 32'd1);
    run("mode0_awdly", 2'd0, 32'h0, 32'd1, 32'd0);
    check_writes("mode0_awdly");
    chk("mode0_wvalid_dropped_first", 32'(wdrop_n - wd0 >= 8), 32'd1);
    chk("mode0_aw_stable", 32'(unstable_n), 32'd0);
    aw_delay = 0;

    // Error response on the first write ends the sequence.
    err_at = wr_n;
    aw0 = aw_n;
    push(32'h4040_0018, 32'h3000_0000);
    run("berr", 2'd1, 32'h3000_0000, 32'd8, 32'd0);
    check_writes("berr");
    chk("berr_aw_count", 32'(aw_n - aw0), 32'd1);
    chk("berr_error", {31'd0, O_ERROR}, 32'd1);
    chk("berr_done_latency", 32'(done_cyc), 32'(last_b_cyc + 1));
    err_at = -1;

    // N=0 counts as one iteration; buffer address wraps past 2^32; sticky error clears.
    push(32'h4040_0048, 32'hFFFF_FFF0);
    push(32'h4040_0058, 32'h20);
`ifdef DMA_REG_SEQ_POLL_EN
    push(32'h4040_0034, 32'h0000_1000);
`endif
    run("n0", 2'd2, 32'hFFFF_FFF0, 32'h20, 32'd0);
    check_writes("n0");
    chk("n0_error_cleared", {31'd0, O_ERROR}, 32'd0);
    push(32'h4040_0048, 32'hFFFF_FFF0);
    push(32'h4040_0058, 32'h20);
`ifdef DMA_REG_SEQ_POLL_EN
    push(32'h4040_0034, 32'h0000_1000);
`endif
    push(32'h4040_0048, 32'h0000_0010);
    push(32'h4040_0058, 32'h20);
`ifdef DMA_REG_SEQ_POLL_EN
    push(32'h4040_0034, 32'h0000_1000);
`endif
    run("wrap", 2'd2, 32'hFFFF_FFF0, 32'h20, 32'd2);
    check_writes("wrap");

`ifdef DMA_REG_SEQ_POLL_EN
    // SR polling: two not-done reads, then IOC.
    sr_base = rd_n; sr_len = 3;
    sr_arr[0] = 32'h0; sr_arr[1] = 32'h0; sr_arr[2] = 32'h0000_1000;
    aw0 = rd_n;
    push(32'h4040_0018, 32'h1000_0000);
    push(32'h4040_0028, 32'd64);
    push(32'h4040_0004, 32'h0000_1000);
    run("poll", 2'd1, 32'h1000_0000, 32'd64, 32'd0);
    check_writes("poll");
    chk("poll_reads", 32'(rd_n - aw0), 32'd3);
    chk("poll_araddr", last_ar, 32'h4040_0004);
    chk("poll_error", {31'd0, O_ERROR}, 32'd0);
    // DMA error bit in SR.
    sr_base = rd_n; sr_len = 1; sr_arr[0] = 32'h0000_0010;
    push(32'h4040_0018, 32'h1000_0000);
    push(32'h4040_0028, 32'd64);
    run("poll_err", 2'd1, 32'h1000_0000, 32'd64, 32'd0);
    check_writes("poll_err");
    chk("poll_err_error", {31'd0, O_ERROR}, 32'd1);
    sr_len = 0;
`endif

    // Reset while AWVALID is up, then an illegal-mode request.
    aw_delay = 50;
    @(negedge clk);
    I_TRANSFER_MODE = 2'd1; I_REG_ADDRESS = 32'h5000_0000; I_REG_DATA = 32'd4;
    I_INIT_AXI_TXN = 1'b1;
    @(negedge clk);
    I_INIT_AXI_TXN = 1'b0;
    for (int i = 0; i < 20 && !M_AXI_AWVALID; i++) @(negedge clk);
    chk("rst_mid_awvalid_seen", {31'd0, M_AXI_AWVALID}, 32'd1);
    I_ARESET = 1'b1;
    #1;
    chk("rst_mid_valids", {28'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID}, 32'd0);
    chk("rst_mid_awaddr", M_AXI_AWADDR, 32'd0);
    chk("rst_mid_wdata", M_AXI_WDATA, 32'd0);
    chk("rst_mid_done_err", {30'd0, O_AXI_TXN_DONE, O_ERROR}, 32'd0);
    repeat (2) @(negedge clk);
    I_ARESET = 1'b0;
    aw_delay = 0;
    aw0 = aw_n;
    run("mode3", 2'd3, 32'h0, 32'h0, 32'd0);
    chk("mode3_error", {31'd0, O_ERROR}, 32'd1);
    chk("mode3_no_aw", 32'(aw_n - aw0), 32'd0);
    check_writes("mode3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
